// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core's data-memory path.
package core_mem_pkg;

  localparam int MAX_LATENCY = 4;
  localparam int WORD_BYTES  = 4;

  // Loads and stores share the size encodings; BU/HU exist only for loads.
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } func3_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

endpackage

// File: rtl/core_load_extract.sv
// Lane select plus sign/zero extension of a raw 32-bit word for RISC-V loads.
module core_load_extract
  import core_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[8*lane +: 8];
    sel_half = lane[1] ? word[31:16] : word[15:0];
    data     = '0;
    case (func3)
      F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    data = {{16{sel_half[15]}}, sel_half};
      F3_W:    data = word;
      F3_BU:   data = {24'h0, sel_byte};
      F3_HU:   data = {16'h0, sel_half};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/core_dmem_responder.sv
// Data-memory slave for the core load/store port with configurable response latency.
// Optional periodic back-pressure is enabled by defining DMEM_STALL_EN.
module core_dmem_responder
  import core_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1
`ifdef DMEM_STALL_EN
  ,
  parameter int          STALL_PERIOD = 4
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int LAT = (LATENCY < 1) ? 1 : ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS * WORD_BYTES);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // the requester must hold its request unchanged while req_ready is low.
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic [32:0]   diff;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          in_range;
  logic          f3_ok;
  logic          misalign;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic [31:0]   raw;
  logic [31:0]   ld_data;
  mem_rsp_t      rsp_d;
  mem_rsp_t      pipe [LAT];

  assign accept = req_valid && req_ready;

  // The extra top bit of diff is the borrow, flagging addresses below BASE_ADDR.
  assign diff     = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign in_range = !diff[32] && (diff < SPAN);
  assign widx     = diff[AW+1:2];
  assign lane     = diff[1:0];

  always_comb begin
    f3_ok = 1'b0;
    case (req_func3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_we;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign misalign = ((req_func3[1:0] == 2'b01) && lane[0]) ||
                    ((req_func3[1:0] == 2'b10) && (lane != 2'b00));
  assign err      = !in_range || !f3_ok || misalign;

  always_comb begin
    be   = 4'b1111;
    wrep = req_wdata;
    case (req_func3[1:0])
      2'b00: begin
        be   = 4'b0001 << lane;
        wrep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{req_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = req_wdata;
      end
    endcase
  end

  // Write lands on the accept edge, so a load accepted one cycle later sees it.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign raw = mem[widx];

  core_load_extract u_extract (
    .func3 (req_func3),
    .lane  (lane),
    .word  (raw),
    .data  (ld_data)
  );

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = accept;
    rsp_d.err   = accept && err;
    rsp_d.rdata = (accept && !req_we && !err) ? ld_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rsp_d;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rsp_valid = pipe[LAT-1].valid;
  assign rsp_rdata = pipe[LAT-1].rdata;
  assign rsp_err   = pipe[LAT-1].err;

`ifdef DMEM_STALL_EN
  localparam int CW = (STALL_PERIOD < 2) ? 1 : $clog2(STALL_PERIOD);

  logic [CW-1:0] stall_cnt;
  logic          stall_q;

  // Every STALL_PERIOD-th accept wraps the counter and blocks the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_q   <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      if (accept) begin
        if (stall_cnt == CW'(STALL_PERIOD - 1)) begin
          stall_cnt <= '0;
          stall_q   <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
    end
  end

  assign req_ready = !stall_q;
`else
  assign req_ready = 1'b1;
`endif

endmodule

// File: tb/tb_core_dmem_responder.sv
// Directed bench for core_dmem_responder: a LATENCY=1 instance at base 0 and a
// LATENCY=3 instance at base 0x1000, both 16 words deep.
module tb_core_dmem_responder;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, v1, we1, rdy1, rv1, re1;
  logic [2:0]  f1;
  logic [31:0] a1, wd1, rd1;
  logic        rst3, v3, we3, rdy3, rv3, re3;
  logic [2:0]  f3;
  logic [31:0] a3, wd3, rd3;

  core_dmem_responder #(
    .DEPTH_WORDS (16),
    .BASE_ADDR   (32'h0000_0000),
    .LATENCY     (1)
`ifdef DMEM_STALL_EN
    , .STALL_PERIOD (4)
`endif
  ) u1 (
    .clk (clk), .rst (rst1), .req_valid (v1), .req_ready (rdy1), .req_we (we1),
    .req_func3 (f1), .req_addr (a1), .req_wdata (wd1),
    .rsp_valid (rv1), .rsp_rdata (rd1), .rsp_err (re1)
  );

  core_dmem_responder #(
    .DEPTH_WORDS (16),
    .BASE_ADDR   (32'h0000_1000),
    .LATENCY     (3)
`ifdef DMEM_STALL_EN
    , .STALL_PERIOD (64)
`endif
  ) u3 (
    .clk (clk), .rst (rst3), .req_valid (v3), .req_ready (rdy3), .req_we (we3),
    .req_func3 (f3), .req_addr (a3), .req_wdata (wd3),
    .rsp_valid (rv3), .rsp_rdata (rd3), .rsp_err (re3)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [25];

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Presents one request to u1, waits (bounded) for req_ready, and returns at the
  // falling edge after the accept edge, where the response is visible.
  task automatic send1(input logic we, input logic [2:0] fn, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    v1 = 1'b1; we1 = we; f1 = fn; a1 = addr; wd1 = wdata;
    while (!rdy1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy1) chk("u1_ready_timeout", {31'h0, rdy1}, 32'h1);
    @(negedge clk);
    v1 = 1'b0;
  endtask

  // One request to u3, returning at the falling edge where its response shows.
  task automatic send3(input logic we, input logic [2:0] fn, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(negedge clk);
    v3 = 1'b1; we3 = we; f3 = fn; a3 = addr; wd3 = wdata;
    @(negedge clk);
    v3 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] exp3 [5];
  bit          exp_v;
  int          pulses;

  initial begin
    vecs[0]  = '{1'b1, SW,     32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, LW,     32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, SB,     32'h13, 32'hAAAAAA80, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, LB,     32'h13, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, LBU,    32'h13, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, LW,     32'h10, 32'h0,        32'h80ADBEEF, 1'b0};
    vecs[6]  = '{1'b1, SH,     32'h11, 32'h00001234, 32'h00000000, 1'b1};
    vecs[7]  = '{1'b0, LW,     32'h12, 32'h0,        32'h00000000, 1'b1};
    vecs[8]  = '{1'b0, LW,     32'h10, 32'h0,        32'h80ADBEEF, 1'b0};
    vecs[9]  = '{1'b1, SW,     32'h40, 32'h12345678, 32'h00000000, 1'b1};
    vecs[10] = '{1'b0, LW,     32'h40, 32'h0,        32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h00000000, 1'b1};
    vecs[12] = '{1'b1, 3'b011, 32'h10, 32'h0,        32'h00000000, 1'b1};
    vecs[13] = '{1'b0, LW,     32'h10, 32'h0,        32'h80ADBEEF, 1'b0};
    vecs[14] = '{1'b1, SH,     32'h16, 32'hCAFE8001, 32'h00000000, 1'b0};
    vecs[15] = '{1'b0, LH,     32'h16, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[16] = '{1'b0, LHU,    32'h16, 32'h0,        32'h00008001, 1'b0};
    vecs[17] = '{1'b0, LB,     32'h16, 32'h0,        32'h00000001, 1'b0};
    vecs[18] = '{1'b0, LB,     32'h17, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[19] = '{1'b1, SW,     32'h3C, 32'h11223344, 32'h00000000, 1'b0};
    vecs[20] = '{1'b0, LW,     32'h3C, 32'h0,        32'h11223344, 1'b0};
    vecs[21] = '{1'b0, LH,     32'h3C, 32'h0,        32'h00003344, 1'b0};
    vecs[22] = '{1'b0, 3'b110, 32'h10, 32'h0,        32'h00000000, 1'b1};
    vecs[23] = '{1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[24] = '{1'b0, LW,     32'h10, 32'h0,        32'h80ADBEEF, 1'b0};

    // Clock/reset
    rst1 = 1'b1; v1 = 1'b0; we1 = 1'b0; f1 = 3'b0; a1 = 32'h0; wd1 = 32'h0;
    rst3 = 1'b1; v3 = 1'b0; we3 = 1'b0; f3 = 3'b0; a3 = 32'h0; wd3 = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_u1_valid", {31'h0, rv1}, 32'h0);
    chk("rst_u1_rdata", rd1, 32'h0);
    chk("rst_u1_err", {31'h0, re1}, 32'h0);
    chk("rst_u1_ready", {31'h0, rdy1}, 32'h1);
    chk("rst_u3_valid", {31'h0, rv3}, 32'h0);
    chk("rst_u3_ready", {31'h0, rdy3}, 32'h1);
    rst1 = 1'b0;
    rst3 = 1'b0;

    // Table-driven single accesses on the LATENCY=1 instance
    for (int i = 0; i < 25; i++) begin
      send1(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_valid", i), {31'h0, rv1}, 32'h1);
      chk($sformatf("vec%0d_rdata", i), rd1, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'h0, re1}, {31'h0, vecs[i].exp_err});
    end

    // Read-after-write: store then load to the same word on consecutive edges
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    v1 = 1'b1; we1 = 1'b1; f1 = SW; a1 = 32'h20; wd1 = 32'h55667788;
    @(negedge clk);
    chk("raw_store_valid", {31'h0, rv1}, 32'h1);
    chk("raw_store_rdata", rd1, 32'h0);
    we1 = 1'b0; f1 = LW;
    @(negedge clk);
    v1 = 1'b0;
    chk("raw_load_valid", {31'h0, rv1}, 32'h1);
    chk("raw_load_rdata", rd1, 32'h55667788);
    @(negedge clk);
    chk("idle_valid", {31'h0, rv1}, 32'h0);
    chk("idle_rdata", rd1, 32'h0);
    chk("idle_err", {31'h0, re1}, 32'h0);

    // A store on the same edge as reset must not land
    rst1 = 1'b1;
    v1 = 1'b1; we1 = 1'b1; f1 = SW; a1 = 32'h10; wd1 = 32'h99999999;
    @(negedge clk);
    rst1 = 1'b0;
    v1 = 1'b0;
    chk("rst_store_valid", {31'h0, rv1}, 32'h0);
    send1(1'b0, LW, 32'h10, 32'h0);
    chk("rst_store_nowrite", rd1, 32'h80ADBEEF);

    // LATENCY=3: preload five words, then five back-to-back loads
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      v3 = 1'b1; we3 = 1'b1; f3 = SW; a3 = 32'h1000 + 32'(4 * k); wd3 = 32'hA5A50000 + 32'(k);
    end
    @(negedge clk);
    v3 = 1'b0;
    repeat (5) @(negedge clk);
    exp3[0] = 32'hA5A50000;
    exp3[1] = 32'h0000A5A5;
    exp3[2] = 32'hA5A50002;
    exp3[3] = 32'hFFFFFFA5;
    exp3[4] = 32'hA5A50004;
    for (int c = 0; c < 9; c++) begin
      exp_v = (c >= 3) && (c <= 7);
      chk($sformatf("lat3_c%0d_valid", c), {31'h0, rv3}, {31'h0, exp_v});
      chk($sformatf("lat3_c%0d_rdata", c), rd3, exp_v ? exp3[c-3] : 32'h0);
      if (c < 5) begin
        v3 = 1'b1; we3 = 1'b0; a3 = 32'h1000 + 32'(4 * c);
        f3 = (c == 1) ? LHU : ((c == 3) ? LB : LW);
        if (c == 1) a3 = 32'h1006;
        if (c == 3) a3 = 32'h100F;
      end else begin
        v3 = 1'b0;
      end
      @(negedge clk);
    end

    // Reset after the second accept drops everything in flight
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("midrst_c%0d_valid", c), {31'h0, rv3}, 32'h0);
      if (c < 3) begin
        v3 = 1'b1; we3 = 1'b0; f3 = LW; a3 = 32'h1000 + 32'(4 * c);
        rst3 = (c == 2);
      end else begin
        v3 = 1'b0;
        rst3 = 1'b0;
      end
      @(negedge clk);
    end

    // Range boundaries around BASE_ADDR on the LATENCY=3 instance
    send3(1'b0, LW, 32'h0FFC, 32'h0);
    chk("below_base_err", {31'h0, re3}, 32'h1);
    chk("below_base_rdata", rd3, 32'h0);
    send3(1'b1, SW, 32'h1040, 32'hDEADDEAD);
    chk("above_top_err", {31'h0, re3}, 32'h1);
    send3(1'b1, SW, 32'h0FFC, 32'hDEADDEAD);
    chk("below_base_st_err", {31'h0, re3}, 32'h1);
    send3(1'b0, LW, 32'h1000, 32'h0);
    chk("lat3_unchanged", rd3, 32'hA5A50000);
    chk("lat3_unchanged_err", {31'h0, re3}, 32'h0);
    send3(1'b0, LW, 32'h103C, 32'h0);
    chk("top_word_ok_err", {31'h0, re3}, 32'h0);

`ifdef DMEM_STALL_EN
    // Continuous requests: ready drops for one cycle after every 4th accept
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    pulses = 0;
    v1 = 1'b1; we1 = 1'b0; f1 = LW; a1 = 32'h10;
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("stall_c%0d_ready", c), {31'h0, rdy1}, {31'h0, ((c % 5) != 4)});
      @(negedge clk);
      if (rv1) pulses++;
    end
    v1 = 1'b0;
    @(negedge clk);
    chk("stall_pulse_count", 32'(pulses), 32'd12);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
